// File: rtl/shared_resource_pkg.sv
// Shared types and helpers for pipelined shared-resource blocks.
// Datapath fields are sized for the widest supported configuration; users keep only the low bits.
package shared_resource_pkg;

  localparam int MAX_W  = 64;
  localparam int MAX_CH = 16;

  // Index width for an n-way selection, never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic [MAX_CH-1:0] tag;
    logic [MAX_W-1:0]  data;
    logic              ovf;
  } stage_t;

  // Returns {ovf, result}: result is data << shift kept to 'width' bits, ovf flags lost nonzero bits.
  function automatic logic [MAX_W:0] scale(input logic [MAX_W-1:0] data,
                                           input int unsigned shift,
                                           input int unsigned width = MAX_W);
    logic [2*MAX_W-1:0] wide;
    logic [2*MAX_W-1:0] mask;
    wide = {{MAX_W{1'b0}}, data} << shift;
    mask = ({{(2*MAX_W-1){1'b0}}, 1'b1} << width) - 1'b1;
    return {|(wide & ~mask), wide[MAX_W-1:0] & mask[MAX_W-1:0]};
  endfunction

endpackage

// File: rtl/shared_resource_rr_if.sv
// Request/result bundle between the channel pipelines and the shared resource.
interface shared_resource_rr_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 2
);
  logic                    stall;
  logic [NUM_CH-1:0]       req_valid;
  logic [NUM_CH*WIDTH-1:0] req_data;
  logic [NUM_CH-1:0]       req_ready;
  logic [NUM_CH-1:0]       out_valid;
  logic [WIDTH-1:0]        out_data;
  logic                    out_ovf;
  logic                    busy;

  modport master (output stall, req_valid, req_data,
                  input  req_ready, out_valid, out_data, out_ovf, busy);
  modport slave  (input  stall, req_valid, req_data,
                  output req_ready, out_valid, out_data, out_ovf, busy);
endinterface

// File: rtl/shared_resource_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr (wrapping) wins; en gates the grant.
module rr_arbiter
  import shared_resource_pkg::*;
#(
  parameter int N = 2,
  parameter int W = ch_w(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  input  logic         en_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] idx_o
);

  always_comb begin
    logic found;
    int   c;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    c       = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr_i) + k) % N;
      if (!found && req_i[c]) begin
        found      = 1'b1;
        grant_o[c] = en_i;
        idx_o      = W'(c);
      end
    end
  end

endmodule

// File: rtl/shared_resource_rr.sv
// Shared scaling resource: round-robin grant among channels, operand << SHIFT, LATENCY-deep pipe.
// Results return tagged one-hot with the owning channel; the global stall freezes everything.
module shared_resource_rr
  import shared_resource_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_CH  = 2,
  parameter int LATENCY = 1,
  parameter int SHIFT   = 1
) (
  input  logic                clk,
  input  logic                reset,
  shared_resource_rr_if.slave bus
);

  localparam int CH_W = ch_w(NUM_CH);

  logic [CH_W-1:0]   ptr_q;
  logic [CH_W-1:0]   idx;
  logic [NUM_CH-1:0] grant;
  logic              accept;
  logic [WIDTH-1:0]  operand;
  logic [MAX_W:0]    scaled;
  stage_t            stage_d;
  stage_t            stage_q [LATENCY];
  logic              busy_c;

  rr_arbiter #(.N(NUM_CH), .W(CH_W)) u_arb (
    .req_i   (bus.req_valid),
    .ptr_i   (ptr_q),
    .en_i    (~bus.stall & ~reset),
    .grant_o (grant),
    .idx_o   (idx)
  );

  assign bus.req_ready = grant;
  assign accept        = |grant;

  // Stage 0 input: granted operand scaled, or a bubble when nothing is accepted
  always_comb begin
    operand = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx == CH_W'(i)) operand = bus.req_data[i*WIDTH +: WIDTH];
    end
    scaled  = scale(MAX_W'(operand), SHIFT, WIDTH);
    stage_d = '0;
    if (accept) begin
      stage_d.tag  = MAX_CH'(grant);
      stage_d.data = scaled[MAX_W-1:0];
      stage_d.ovf  = scaled[MAX_W];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < LATENCY; k++) stage_q[k] <= '0;
    end else if (!bus.stall) begin
      stage_q[0] <= stage_d;
      for (int k = 1; k < LATENCY; k++) stage_q[k] <= stage_q[k-1];
    end
  end

  // A single channel needs no rotation, so the pointer collapses to a constant
  if (NUM_CH > 1) begin : g_ptr
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ptr_q <= '0;
      end else if (!bus.stall && accept) begin
        ptr_q <= (idx == CH_W'(NUM_CH-1)) ? '0 : idx + 1'b1;
      end
    end
  end else begin : g_noptr
    assign ptr_q = '0;
  end

  always_comb begin
    busy_c = 1'b0;
    for (int k = 0; k < LATENCY; k++) busy_c = busy_c | (|stage_q[k].tag);
  end

  assign bus.out_valid = NUM_CH'(stage_q[LATENCY-1].tag);
  assign bus.out_data  = WIDTH'(stage_q[LATENCY-1].data);
  assign bus.out_ovf   = stage_q[LATENCY-1].ovf;
  assign bus.busy      = busy_c;

endmodule

// File: tb/tb_shared_resource_rr.sv
// Randomized and directed bench for shared_resource_rr against a queue-based reference model.
module tb_shared_resource_rr;
  localparam int W   = 32;
  localparam int NCH = 3;
  localparam int LAT = 3;
  localparam int SH  = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shared_resource_rr_if #(.WIDTH(W), .NUM_CH(NCH)) bus ();

  shared_resource_rr #(.WIDTH(W), .NUM_CH(NCH), .LATENCY(LAT), .SHIFT(SH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [NCH-1:0] tag;
    logic [W-1:0]   data;
    logic           ovf;
  } res_t;

  res_t line[$];
  int   ptr_m;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic res_t bubble();
    res_t r;
    r.tag = '0; r.data = '0; r.ovf = 1'b0;
    return r;
  endfunction

  // Result of operand * 2^SH, kept to W bits, with overflow if anything spilled above W
  function automatic res_t make_res(input int ch, input logic [W-1:0] op);
    res_t r;
    logic [63:0] p;
    p = 64'(op) * (64'd1 << SH);
    r.tag = '0;
    r.tag[ch] = 1'b1;
    r.data = p[W-1:0];
    r.ovf  = (p >> W) != 64'd0;
    return r;
  endfunction

  function automatic logic [NCH*W-1:0] pack(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [W-1:0] c);
    return {c, b, a};
  endfunction

  task automatic model_flush();
    line.delete();
    for (int k = 0; k < LAT; k++) line.push_back(bubble());
    ptr_m = 0;
  endtask

  task automatic check_outputs(input string ph);
    logic any;
    any = 1'b0;
    foreach (line[k]) any = any | (|line[k].tag);
    check_val({ph, "_out_valid"}, 64'(bus.out_valid), 64'(line[0].tag));
    check_val({ph, "_out_data"},  64'(bus.out_data),  64'(line[0].data));
    check_val({ph, "_out_ovf"},   64'(bus.out_ovf),   64'(line[0].ovf));
    check_val({ph, "_busy"},      64'(bus.busy),      64'(any));
  endtask

  // One cycle: drive at the falling edge, check grant, advance model, check outputs after the edge
  task automatic step(input string ph, input logic [NCH-1:0] v, input logic [NCH*W-1:0] d,
                      input logic st);
    int g;
    logic [NCH-1:0] exp_rdy;
    res_t r;
    bus.req_valid = v;
    bus.req_data  = d;
    bus.stall     = st;
    #1;
    g = -1;
    for (int k = 0; k < NCH; k++) begin
      if (g < 0 && v[(ptr_m + k) % NCH]) g = (ptr_m + k) % NCH;
    end
    exp_rdy = '0;
    if (g >= 0 && !st) exp_rdy[g] = 1'b1;
    check_val({ph, "_req_ready"}, 64'(bus.req_ready), 64'(exp_rdy));
    if (!st) begin
      if (g >= 0) begin
        r = make_res(g, d[g*W +: W]);
        ptr_m = (g + 1) % NCH;
      end else begin
        r = bubble();
      end
      line.push_back(r);
      void'(line.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(ph);
  endtask

  task automatic do_reset(input string ph);
    reset = 1'b1;
    #1;
    check_val({ph, "_rst_out_valid"}, 64'(bus.out_valid), 64'd0);
    check_val({ph, "_rst_out_data"},  64'(bus.out_data),  64'd0);
    check_val({ph, "_rst_out_ovf"},   64'(bus.out_ovf),   64'd0);
    check_val({ph, "_rst_busy"},      64'(bus.busy),      64'd0);
    check_val({ph, "_rst_ready"},     64'(bus.req_ready), 64'd0);
    model_flush();
    @(posedge clk);
    @(negedge clk);
    check_outputs({ph, "_rst_hold"});
    reset = 1'b0;
  endtask

  initial begin
    logic [NCH-1:0]   v;
    logic [NCH*W-1:0] d;
    logic             st;
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.stall     = 1'b0;
    @(negedge clk);
    do_reset("init");

    // Single channel request, then drain
    step("single", 3'b001, pack(32'h5, 32'h0, 32'h0), 1'b0);
    for (int k = 0; k < LAT; k++) step("single", '0, '0, 1'b0);

    // Two channels competing continuously
    for (int k = 0; k < 6; k++) step("rr", 3'b011, pack(32'h1, 32'h2, 32'h0), 1'b0);
    // All three competing
    for (int k = 0; k < 6; k++) step("rr3", 3'b111, pack(32'h11, 32'h22, 32'h33), 1'b0);
    for (int k = 0; k < LAT; k++) step("rr", '0, '0, 1'b0);

    // Overflow from the top bit
    step("ovf", 3'b010, pack(32'h0, 32'h8000_0001, 32'h0), 1'b0);
    step("ovf", 3'b100, pack(32'h0, 32'h0, 32'hFFFF_FFFF), 1'b0);
    for (int k = 0; k < LAT; k++) step("ovf", '0, '0, 1'b0);

    // Accept then hold stall with requests still pending
    step("stall", 3'b001, pack(32'h3, 32'h0, 32'h0), 1'b0);
    for (int k = 0; k < 3; k++) step("stall", 3'b111, pack(32'h7, 32'h8, 32'h9), 1'b1);
    for (int k = 0; k < LAT + 1; k++) step("stall", '0, '0, 1'b0);

    // Every other cycle on channel 1
    for (int k = 0; k < 8; k++) step("bub", (k % 2 == 0) ? 3'b010 : 3'b000,
                                     pack(32'h0, 32'h40 + k, 32'h0), 1'b0);
    for (int k = 0; k < LAT + 1; k++) step("bub", '0, '0, 1'b0);

    // Reset with results in flight: none may be delivered afterwards
    step("rbusy", 3'b001, pack(32'hA, 32'h0, 32'h0), 1'b0);
    step("rbusy", 3'b010, pack(32'h0, 32'hB, 32'h0), 1'b0);
    do_reset("rbusy");
    for (int k = 0; k < LAT + 1; k++) step("rbusy", '0, '0, 1'b0);

    // Random traffic with occasional stalls and one mid-run reset
    for (int n = 0; n < 400; n++) begin
      v  = NCH'($urandom);
      st = ($urandom_range(0, 4) == 0);
      for (int c = 0; c < NCH; c++) begin
        case ($urandom_range(0, 3))
          0:       d[c*W +: W] = 32'h8000_0000 | W'($urandom);
          1:       d[c*W +: W] = W'($urandom_range(0, 15));
          default: d[c*W +: W] = W'($urandom);
        endcase
      end
      step("rand", v, d, st);
      if (n == 200) do_reset("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/shared_resource_rr.md
# shared_resource_rr

Parametrised, pipelined shared datapath resource serving NUM_CH requesting pipeline channels. Each cycle a round-robin arbiter grants at most one valid requester. Its operand is scaled by 2^SHIFT and carried through LATENCY register stages, then returned with a one-hot channel tag. The block sits between the per-channel pipelines and their shared execution unit, and obeys the design-wide global stall.

## Interface
- WIDTH, 32, operand/result width in bits
- NUM_CH, 2, number of requesting channels (1..16)
- LATENCY, 1, number of pipeline register stages (1..8)
- SHIFT, 1, left-shift amount; result = operand × 2^SHIFT (0..WIDTH-1)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  global stall; freezes all state
- req_valid  in  NUM_CH  per-channel request valid
- req_data  in  NUM_CH*WIDTH  per-channel operand; channel i at bits [i*WIDTH +: WIDTH]
- req_ready  out  NUM_CH  one-hot grant, combinational
- out_valid  out  NUM_CH  one-hot channel tag of the result in the last stage; zero = bubble
- out_data  out  WIDTH  result, truncated to WIDTH bits
- out_ovf  out  1  high with a valid result when any nonzero bit was shifted out above WIDTH
- busy  out  1  OR of all stage valids

## Operation
- Arbitration: a priority pointer `ptr` is reset to 0.
  - Grant goes to the first channel with req_valid set, searching ptr, ptr+1, … NUM_CH-1, 0, … (wrapping).
  - req_ready is the grant AND ~stall AND ~reset. It is never multi-hot.
- Accept: a transfer happens on channel i when req_valid[i] & req_ready[i].
  - Stage 0 captures {tag = one-hot i, data = req_data_i << SHIFT truncated, ovf = OR of the shifted-out bits}.
  - ptr becomes (i+1) mod NUM_CH.
- No accept: when there is no valid request and stall is low, stage 0 loads a bubble (tag 0, data 0, ovf 0), and ptr holds.
- Pipeline: when stall is low, stage k+1 takes stage k on every edge. Outputs are driven directly from the last stage registers.
- Stall high:
  - every stage, ptr and the outputs hold their values;
  - req_ready is all zeros;
  - a held out_valid remains asserted and stalled consumers do not re-consume it.
- There is no per-channel backpressure on the output. Consumers always accept the result unless they are globally stalled.
- NUM_CH = 1: ptr is absent; req_ready = ~stall.
- A channel's req_data is ignored when it is not granted.

## Timing
- Reset (asynchronous, takes effect immediately): all stage valids/tags 0, data 0, ovf 0, ptr 0. So out_valid = 0, out_data = 0, out_ovf = 0, busy = 0.
  - Reset during operation flushes all in-flight results; they are never delivered.
- Latency: an operand accepted on edge t appears on the outputs after edge t+LATENCY-1, visible in the cycle that follows it. Each stall cycle in between adds one cycle.
- Throughput: one accept per non-stalled cycle, spread across channels.
- Fairness: with all channels requesting continuously, each channel is granted exactly once every NUM_CH non-stalled cycles.
- Stall changes take effect on the same edge. An accept cannot occur on an edge where stall is high.

## Structure
- Package shared_resource_pkg holds:
  - CH_W = $clog2(NUM_CH) with a minimum of 1;
  - the stage struct typedef (tag, data, ovf);
  - the function scale(data, shift) returning {ovf, result}.
- Sub-module rr_arbiter (parameter N; inputs req, ptr, en; outputs a one-hot grant and the granted index). Reused by future shared blocks.
- The top level contains the stage shift-register array, the ptr register and the output assignment.

## Test plan
- Reset during busy: with LATENCY=3 and 2 results in flight, assert reset → out_valid=0, busy=0 immediately, and nothing is delivered afterwards.
- Single channel: NUM_CH=2, LATENCY=1, SHIFT=1, ch0 req 0x0000_0005 → req_ready=01, out_valid=01 and out_data=0x0000_000A on the next cycle, out_ovf=0.
- Round-robin: both channels request continuously, ch0=0x1, ch1=0x2 → grants alternate 01,10,01,10 and outputs alternate 0x2 (tag 01) / 0x4 (tag 10).
- Overflow: SHIFT=1, operand 0x8000_0001 → out_data=0x0000_0002, out_ovf=1.
- Stall: LATENCY=2, accept 0x3 then stall for 3 cycles → req_ready=00 while stalled, pipeline frozen, out_data=0x6 arrives 3 cycles later than unstalled; pointer unchanged across the stall.
- Bubbles/idle: request every other cycle on ch1 → out_valid pattern 10,00,10,00 after the latency, and busy deasserts LATENCY cycles after the last accept.
